// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main control FSM for the 16-bit multicycle processor. One instruction at a
// time is sequenced through fetch, decode, execute, memory and writeback, and
// every datapath select line and storage enable is driven from here.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; next state is FETCH
//   opcode     in   [3:0] instr[15:12] from the IR register
//   zero       in   ALU zero flag, qualifies the BEQ PC load
//   mem_ready  in   memory finishes the current read/write this cycle
//   pc_en      out  PC load (branch condition already folded in)
//   ir_write   out  IR load
//   i_or_d     out  memory address: 0 = PC, 1 = ALUOut
//   mem_read   out  memory read request (held while waiting)
//   mem_write  out  memory write request (held while waiting)
//   reg_write  out  register-file write
//   reg_dst    out  write register: 0 = rd field, 1 = {2'b11, d1}
//   mem_to_reg out  write data: 0 = ALUOut, 1 = MDR
//   alu_src_a  out  0 = PC, 1 = register A
//   alu_src_b  out  [1:0] 00 = B, 01 = 2, 10 = ext imm, 11 = ext imm << 1
//   alu_op     out  [1:0] 00 = add, 01 = sub, 10 = function from opcode
//   pc_src     out  0 = ALU result, 1 = ALUOut
//   rd1_sel    out  [1:0] read-register-1 mux select (from opcode)
//   imm_sel    out  [1:0] 00 = zext8, 01 = sext8, 10 = sext12 (from opcode)
//   halted     out  FSM is parked in HALT
//   state      out  [3:0] current state encoding, for debug
//
// Structure: the state register and a registered copy of that state's Moore
// control word are updated together in one clocked block. The registered word
// is then qualified combinationally by mem_ready (FETCH loads), zero (BRANCH
// PC load) and reset (all enables forced low while reset is high).
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_src,
  output logic [1:0] rd1_sel,
  output logic [1:0] imm_sel,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    WB_R     = 4'd7,
    EXEC_I   = 4'd8,
    WB_I     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_HALT
  } op_class_t;

  // Moore control word for one state. The in_* flags mark the states whose
  // enables need a same-cycle qualifier from an input.
  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_src;
    logic       halted;
    logic       in_fetch;
    logic       in_branch;
    logic       in_wb_i;
  } ctrl_t;

  // ---------------------------------------------------------------------------
  // Opcode classification
  // ---------------------------------------------------------------------------
  function automatic op_class_t classify(input logic [3:0] op);
    op_class_t cls;
    cls = CLS_HALT;
    if (op != HALT_OPCODE) begin
      case (op)
        4'b0000, 4'b0110, 4'b0111, 4'b1001, 4'b1101:          cls = CLS_R;
        4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1010, 4'b1110: cls = CLS_I;
        4'b1000: cls = CLS_LW;
        4'b1011: cls = CLS_SW;
        4'b1100: cls = CLS_BEQ;
        4'b0011: cls = CLS_J;
        default: cls = CLS_HALT;
      endcase
    end
    return cls;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state function
  // ---------------------------------------------------------------------------
  function automatic state_t next_state_of(input state_t    cur,
                                           input op_class_t cls,
                                           input logic      rdy);
    state_t nxt;
    // NOTE: every variable gets a value before any branch, so no path through
    // the case leaves it unassigned; in combinational code that is what keeps
    // synthesis from inferring a latch.
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = rdy ? DECODE : FETCH;
      DECODE: begin
        case (cls)
          CLS_LW, CLS_SW: nxt = MEM_ADDR;
          CLS_R:          nxt = EXEC_R;
          CLS_I:          nxt = EXEC_I;
          CLS_BEQ:        nxt = BRANCH;
          CLS_J:          nxt = JUMP;
          default:        nxt = HALT;
        endcase
      end
      MEM_ADDR: begin
        if (cls == CLS_LW)      nxt = MEM_RD;
        else if (cls == CLS_SW) nxt = MEM_WR;
        else                    nxt = FETCH;
      end
      MEM_RD:   nxt = rdy ? MEM_WB : MEM_RD;
      MEM_WB:   nxt = FETCH;
      MEM_WR:   nxt = rdy ? FETCH : MEM_WR;
      EXEC_R:   nxt = WB_R;
      WB_R:     nxt = FETCH;
      EXEC_I:   nxt = WB_I;
      WB_I:     nxt = FETCH;
      BRANCH:   nxt = FETCH;
      JUMP:     nxt = FETCH;
      HALT:     nxt = HALT;
      // Unused codes 13-15 recover to FETCH on the next edge.
      default:  nxt = FETCH;
    endcase
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Moore decode: control word for a given state
  // ---------------------------------------------------------------------------
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;      // PC + 2
        c.pc_en     = 1'b1;       // qualified by mem_ready
        c.ir_write  = 1'b1;       // qualified by mem_ready
        c.in_fetch  = 1'b1;
      end
      DECODE: begin
        c.alu_src_b = 2'b11;      // ALUOut = PC+2 + (simm8 << 1), branch target
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b11;
      end
      MEM_RD: begin
        c.mem_read  = 1'b1;
        c.i_or_d    = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      WB_R: begin
        c.reg_write = 1'b1;
      end
      EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b10;
      end
      WB_I: begin
        c.reg_write = 1'b1;
        c.in_wb_i   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;      // A - B drives the zero flag
        c.pc_src    = 1'b1;       // load the target computed in DECODE
        c.pc_en     = 1'b1;       // qualified by zero
        c.in_branch = 1'b1;
      end
      JUMP: begin
        c.alu_src_b = 2'b11;
        c.pc_en     = 1'b1;
      end
      HALT: begin
        c.halted    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // State register and registered control word
  // ---------------------------------------------------------------------------
  state_t    cur_state;
  state_t    nxt_state;
  ctrl_t     ctrl_q;
  op_class_t op_class;

  assign op_class = classify(opcode);

  always_comb begin
    nxt_state = next_state_of(cur_state, op_class, mem_ready);
  end

  // The control word is decoded from the state being entered, so it always
  // describes cur_state and the outputs carry no decode logic after the flop.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register in
    // this block samples the pre-edge values, independent of statement order.
    if (reset) begin
      cur_state <= FETCH;
      ctrl_q    <= decode(FETCH);
    end else begin
      cur_state <= nxt_state;
      ctrl_q    <= decode(nxt_state);
    end
  end

  // ---------------------------------------------------------------------------
  // Output qualification
  // ---------------------------------------------------------------------------
  // Enables are killed while reset is high so an aborted instruction leaves
  // no partial PC, IR, register or memory update behind.
  logic run;
  assign run = ~reset;

  assign pc_en     = run & ctrl_q.pc_en
                   & (~ctrl_q.in_fetch  | mem_ready)
                   & (~ctrl_q.in_branch | zero);
  assign ir_write  = run & ctrl_q.ir_write & mem_ready;
  assign mem_read  = run & ctrl_q.mem_read;
  assign mem_write = run & ctrl_q.mem_write;
  assign reg_write = run & ctrl_q.reg_write;

  assign i_or_d     = ctrl_q.i_or_d;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign pc_src     = ctrl_q.pc_src;
  assign halted     = ctrl_q.halted;
  assign state      = cur_state;

  // Only I-type ALU ops 0001/0010 write the fixed {2'b11, d1} register.
  assign reg_dst = ctrl_q.in_wb_i & ((opcode == 4'b0001) | (opcode == 4'b0010));

  // Operand-select decodes depend only on the instruction in IR.
  always_comb begin
    rd1_sel = 2'b10;
    case (opcode)
      4'b0000, 4'b1001, 4'b1010, 4'b1101,
      4'b1110, 4'b0110, 4'b0111, 4'b0011: rd1_sel = 2'b00;
      4'b0001, 4'b0010:                   rd1_sel = 2'b01;
      default:                            rd1_sel = 2'b10;
    endcase
  end

  always_comb begin
    imm_sel = 2'b01;
    case (opcode)
      4'b1010, 4'b1110: imm_sel = 2'b00;
      4'b0011:          imm_sel = 2'b10;
      default:          imm_sel = 2'b01;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Each scenario task walks one instruction
// cycle by cycle against a hand-written state sequence; the expected control
// word for each state comes from a small table written from the state
// descriptions. Inputs change just after the falling edge and outputs are
// sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       pc_src;
  logic [1:0] rd1_sel;
  logic [1:0] imm_sel;
  logic       halted;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .rd1_sel    (rd1_sel),
    .imm_sel    (imm_sel),
    .halted     (halted),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control bundle: state, then every single-bit/bus control.
  logic [18:0] obs;
  assign obs = {state, pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, halted};

  // Expected bundle for a state outside reset, from the per-state table.
  function automatic logic [18:0] expect_out(input logic [3:0] st,
                                             input logic [3:0] op,
                                             input logic       rdy,
                                             input logic       z);
    logic pe, irw, iod, mr, mw, rw, rd, m2r, asa, ps, hl;
    logic [1:0] asb, aop;
    {pe, irw, iod, mr, mw, rw, rd, m2r, asa, ps, hl} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      4'd0:  begin mr = 1'b1; asb = 2'b01; pe = rdy; irw = rdy; end
      4'd1:  begin asb = 2'b11; end
      4'd2:  begin asa = 1'b1; asb = 2'b11; end
      4'd3:  begin mr = 1'b1; iod = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mw = 1'b1; iod = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = 1'b1; end
      4'd8:  begin asa = 1'b1; asb = 2'b10; aop = 2'b10; end
      4'd9:  begin rw = 1'b1; rd = (op == 4'b0001) || (op == 4'b0010); end
      4'd10: begin asa = 1'b1; aop = 2'b01; ps = 1'b1; pe = z; end
      4'd11: begin asb = 2'b11; pe = 1'b1; end
      4'd12: begin hl = 1'b1; end
      default: ;
    endcase
    return {st, pe, irw, iod, mr, mw, rw, rd, m2r, asa, asb, aop, ps, hl};
  endfunction

  // Advance to the next falling edge, apply mem_ready, let outputs settle.
  task automatic cycle(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; opcode = 4'b0000; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk); #1;
    // Still in reset: state is FETCH, but all enables forced low.
    n_checks++;
    if (state !== 4'd0 || mem_read !== 1'b0 || pc_en !== 1'b0 || ir_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: state=%0d mr=%b pe=%b irw=%b, want 0 0 0 0",
               state, mem_read, pc_en, ir_write);
    end
    reset = 1'b0; mem_ready = 1'b0; #1;
    n_checks++;
    if (obs !== expect_out(4'd0, opcode, 1'b0, zero)) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", obs, expect_out(4'd0, opcode, 1'b0, zero));
    end
  endtask

  // R-type 0000: FETCH, DECODE, EXEC_R, WB_R, then FETCH. mem_ready toggled in
  // non-memory states to show it is ignored there.
  task automatic test_r_type();
    int seq[$];
    int rdy[$];
    int n_rw, n_irw, n_pe;
    seq = '{0, 1, 6, 7, 0};
    rdy = '{1, 0, 1, 0, 0};
    opcode = 4'b0000; n_rw = 0; n_irw = 0; n_pe = 0;
    for (int i = 0; i < seq.size(); i++) begin
      cycle(1'(rdy[i]));
      n_rw += int'(reg_write); n_irw += int'(ir_write); n_pe += int'(pc_en);
      n_checks++;
      if (obs !== expect_out(4'(seq[i]), opcode, mem_ready, zero)) begin
        n_fail++;
        $display("FAIL r_type cyc%0d: got %h want %h", i, obs,
                 expect_out(4'(seq[i]), opcode, mem_ready, zero));
      end
    end
    n_checks++;
    if (n_rw != 1 || n_irw != 1 || n_pe != 1) begin
      n_fail++;
      $display("FAIL r_type_pulses: rw=%0d irw=%0d pe=%0d, want 1 1 1", n_rw, n_irw, n_pe);
    end
  endtask

  // LW with 2 FETCH waits and 3 MEM_RD waits: 10 cycles before FETCH returns.
  task automatic test_lw_waits();
    int seq[$];
    int rdy[$];
    int n_wb, n_cyc;
    seq = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 0};
    rdy = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0};
    opcode = 4'b1000; n_wb = 0; n_cyc = 0;
    for (int i = 0; i < seq.size(); i++) begin
      cycle(1'(rdy[i]));
      if (i < 10) n_cyc++;
      if (reg_write && mem_to_reg) n_wb++;
      n_checks++;
      if (obs !== expect_out(4'(seq[i]), opcode, mem_ready, zero)) begin
        n_fail++;
        $display("FAIL lw_waits cyc%0d: got %h want %h", i, obs,
                 expect_out(4'(seq[i]), opcode, mem_ready, zero));
      end
    end
    n_checks++;
    if (n_wb != 1) begin
      n_fail++;
      $display("FAIL lw_mdr_write: count=%0d want 1", n_wb);
    end
  endtask

  // SW with no waits: 4 cycles.
  task automatic test_sw();
    int seq[$];
    int rdy[$];
    seq = '{0, 1, 2, 5, 0};
    rdy = '{1, 0, 0, 1, 0};
    opcode = 4'b1011;
    for (int i = 0; i < seq.size(); i++) begin
      cycle(1'(rdy[i]));
      n_checks++;
      if (obs !== expect_out(4'(seq[i]), opcode, mem_ready, zero)) begin
        n_fail++;
        $display("FAIL sw cyc%0d: got %h want %h", i, obs,
                 expect_out(4'(seq[i]), opcode, mem_ready, zero));
      end
    end
  endtask

  // BEQ taken and not taken: 3 cycles each, pc_en in BRANCH follows zero.
  task automatic test_beq();
    int seq[$];
    int rdy[$];
    seq = '{0, 1, 10, 0};
    rdy = '{1, 1, 1, 0};
    opcode = 4'b1100;
    for (int z = 1; z >= 0; z--) begin
      zero = 1'(z);
      for (int i = 0; i < seq.size(); i++) begin
        cycle(1'(rdy[i]));
        if (seq[i] == 10) begin
          n_checks++;
          if (pc_en !== 1'(z) || pc_src !== 1'b1) begin
            n_fail++;
            $display("FAIL beq_pc_en zero=%0d: pc_en=%b pc_src=%b want %0d 1", z, pc_en, pc_src, z);
          end
        end
        n_checks++;
        if (obs !== expect_out(4'(seq[i]), opcode, mem_ready, zero)) begin
          n_fail++;
          $display("FAIL beq zero=%0d cyc%0d: got %h want %h", z, i, obs,
                   expect_out(4'(seq[i]), opcode, mem_ready, zero));
        end
      end
    end
    zero = 1'b0;
  endtask

  // J: imm_sel=10, rd1_sel=00; JUMP loads PC unconditionally; 3 cycles.
  task automatic test_jump();
    int seq[$];
    int rdy[$];
    seq = '{0, 1, 11, 0};
    rdy = '{1, 0, 0, 0};
    opcode = 4'b0011;
    for (int i = 0; i < seq.size(); i++) begin
      cycle(1'(rdy[i]));
      n_checks++;
      if (obs !== expect_out(4'(seq[i]), opcode, mem_ready, zero)) begin
        n_fail++;
        $display("FAIL jump cyc%0d: got %h want %h", i, obs,
                 expect_out(4'(seq[i]), opcode, mem_ready, zero));
      end
    end
    n_checks++;
    if (imm_sel !== 2'b10 || rd1_sel !== 2'b00) begin
      n_fail++;
      $display("FAIL jump_sel: imm_sel=%b rd1_sel=%b want 10 00", imm_sel, rd1_sel);
    end
  endtask

  // I-type: 0001 writes {2'b11,d1}, 0100 writes rd; 1010 uses zero-ext imm.
  task automatic test_i_type();
    logic [3:0] ops  [3];
    logic [1:0] w_rd1[3];
    logic [1:0] w_imm[3];
    int seq[$];
    int rdy[$];
    ops   = '{4'b0001, 4'b0100, 4'b1010};
    w_rd1 = '{2'b01,   2'b10,   2'b00};
    w_imm = '{2'b01,   2'b01,   2'b00};
    seq = '{0, 1, 8, 9, 0};
    rdy = '{1, 1, 0, 1, 0};
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      for (int i = 0; i < seq.size(); i++) begin
        cycle(1'(rdy[i]));
        n_checks++;
        if (obs !== expect_out(4'(seq[i]), opcode, mem_ready, zero)) begin
          n_fail++;
          $display("FAIL i_type op=%b cyc%0d: got %h want %h", opcode, i, obs,
                   expect_out(4'(seq[i]), opcode, mem_ready, zero));
        end
      end
      n_checks++;
      if (rd1_sel !== w_rd1[k] || imm_sel !== w_imm[k]) begin
        n_fail++;
        $display("FAIL i_type_sel op=%b: rd1_sel=%b imm_sel=%b want %b %b",
                 opcode, rd1_sel, imm_sel, w_rd1[k], w_imm[k]);
      end
    end
  endtask

  // HALT parks for 20 cycles with no enables regardless of inputs; reset exits.
  task automatic test_halt();
    int seq[$];
    int rdy[$];
    seq = '{0, 1};
    rdy = '{1, 0};
    opcode = 4'b1111;
    for (int i = 0; i < seq.size(); i++) begin
      cycle(1'(rdy[i]));
      n_checks++;
      if (obs !== expect_out(4'(seq[i]), opcode, mem_ready, zero)) begin
        n_fail++;
        $display("FAIL halt_entry cyc%0d: got %h want %h", i, obs,
                 expect_out(4'(seq[i]), opcode, mem_ready, zero));
      end
    end
    for (int i = 0; i < 20; i++) begin
      zero = 1'(i % 3 == 0);
      cycle(1'(i % 2));
      n_checks++;
      if (obs !== expect_out(4'd12, opcode, mem_ready, zero)) begin
        n_fail++;
        $display("FAIL halt_hold cyc%0d: got %h want %h", i, obs,
                 expect_out(4'd12, opcode, mem_ready, zero));
      end
    end
    zero = 1'b0;
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; #1;
    @(negedge clk);
    reset = 1'b0; opcode = 4'b0000; #1;
    n_checks++;
    if (state !== 4'd0 || halted !== 1'b0 || mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_reset: state=%0d halted=%b mr=%b want 0 0 1", state, halted, mem_read);
    end
  endtask

  // Reset during a MEM_WR wait: mem_write drops that cycle, FETCH follows.
  task automatic test_reset_mem_wr();
    int seq[$];
    int rdy[$];
    seq = '{0, 1, 2, 5, 5};
    rdy = '{1, 0, 0, 0, 0};
    opcode = 4'b1011;
    for (int i = 0; i < seq.size(); i++) begin
      cycle(1'(rdy[i]));
      n_checks++;
      if (obs !== expect_out(4'(seq[i]), opcode, mem_ready, zero)) begin
        n_fail++;
        $display("FAIL sw_wait cyc%0d: got %h want %h", i, obs,
                 expect_out(4'(seq[i]), opcode, mem_ready, zero));
      end
    end
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; #1;
    n_checks++;
    if (state !== 4'd5 || mem_write !== 1'b0 || reg_write !== 1'b0 || pc_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wr: state=%0d mw=%b rw=%b pe=%b want 5 0 0 0",
               state, mem_write, reg_write, pc_en);
    end
    @(negedge clk);
    reset = 1'b0; #1;
    n_checks++;
    if (obs !== expect_out(4'd0, opcode, mem_ready, zero)) begin
      n_fail++;
      $display("FAIL reset_mid_wr_fetch: got %h want %h", obs,
               expect_out(4'd0, opcode, mem_ready, zero));
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_waits();
    test_sw();
    test_beq();
    test_jump();
    test_i_type();
    test_halt();
    test_reset_mem_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the 16-bit multicycle processor. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives every datapath select line: IorD, RegDst/MemToReg, ALUSrcA, ALUSrcB, PCSrc, the read-register-1 select and the immediate-extend select. It also drives the PC, IR, register-file and memory enables, and stalls on a memory ready handshake.

## Interface
- HALT_OPCODE, 4'b1111, opcode that parks the FSM in HALT until reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  4  instr[15:12] from the IR register
- zero  in  1  ALU zero flag (branch compare)
- mem_ready  in  1  memory completes current read/write this cycle
- pc_en  out  1  PC load enable; already includes the branch condition
- ir_write  out  1  IR load
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register-file write
- reg_dst  out  1  write register: 0 = instr rd field, 1 = {2'b11, d1}
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = reg B, 01 = const 2, 10 = ext imm, 11 = ext imm << 1
- alu_op  out  2  00 = add, 01 = sub, 10 = function from opcode
- pc_src  out  1  0 = ALU result, 1 = ALUOut
- rd1_sel  out  2  read-register-1 mux select
- imm_sel  out  2  00 = zero-ext 8, 01 = sign-ext 8, 10 = sign-ext 12
- halted  out  1  FSM is in HALT
- state  out  4  current state encoding, for debug

## Operation
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
  - EXEC_R=6, WB_R=7, EXEC_I=8, WB_I=9, BRANCH=10, JUMP=11, HALT=12
  - Codes 13–15 go to FETCH on the next edge.
- Opcode classes:
  - R-type: 0000, 0110, 0111, 1001, 1101
  - I-type ALU: 0001, 0010, 0100, 0101, 1010, 1110
  - LW: 1000; SW: 1011; BEQ: 1100; J: 0011; HALT: HALT_OPCODE
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=0.
  - Stays in FETCH while mem_ready=0.
  - When mem_ready=1: ir_write=1 and pc_en=1 for that cycle only, then go to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00, so ALUOut = PC+2 + (simm8<<1) as the branch target.
  - Next state by opcode class: MEM_ADDR (LW/SW), EXEC_R, EXEC_I, BRANCH, JUMP, HALT.
- MEM_ADDR:
  - Drives alu_src_a=1, alu_src_b=11, alu_op=00.
  - Next state: MEM_RD for LW, MEM_WR for SW.
- MEM_RD:
  - Drives mem_read=1, i_or_d=1.
  - Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
- MEM_WR:
  - Drives mem_write=1, i_or_d=1.
  - Waits for mem_ready, then goes to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; then WB_R.
- WB_R: reg_write=1, mem_to_reg=0, reg_dst=0; then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=10; then WB_I.
- WB_I: reg_write=1, mem_to_reg=0; then FETCH.
  - reg_dst=1 for opcodes 0001 and 0010; reg_dst=0 otherwise.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1.
  - pc_en = zero. Then FETCH.
- JUMP:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00, pc_src=0, pc_en=1. Then FETCH.
- HALT: halted=1, all enables 0. Leaves only on reset.
- rd1_sel and imm_sel are combinational from opcode in every state:
  - rd1_sel: 00 for {0000,1001,1010,1101,1110,0110,0111,0011}; 01 for {0001,0010}; 10 otherwise.
  - imm_sel: 00 for {1010,1110}; 10 for 0011; 01 otherwise.
- Any output not listed for a state is 0.

## Timing
- Outputs are Moore decodes of the state register. Exceptions: the FETCH enables are qualified by mem_ready, and BRANCH pc_en by zero.
- Reset:
  - Sampled at the clk edge; the state after that edge is FETCH.
  - While reset=1, pc_en, ir_write, reg_write, mem_write and mem_read are forced to 0, whatever the state.
  - Reset asserted mid-operation (any state, including a memory wait or HALT) aborts the instruction with no partial write; FETCH follows.
- Latency with zero wait states (mem_ready=1 on first request):
  - R-type and I-type: 4 cycles
  - LW: 5 cycles; SW: 4 cycles
  - BEQ and J: 3 cycles
- Each memory wait cycle adds exactly 1 cycle. Requests stay asserted with stable i_or_d while waiting.
- mem_ready is ignored in states without a memory request.
- Enables are asserted for exactly one cycle per instruction. The only exception is mem_read/mem_write, which are held across wait cycles.

## Test plan
- Reset, then R-type opcode 0000, mem_ready=1:
  - States 0→1→6→7→0.
  - ir_write and pc_en high only in cycle 1 of FETCH.
  - reg_write high only in WB_R.
- LW (1000) with mem_ready low for 2 cycles in FETCH and 3 in MEM_RD:
  - Total 10 cycles.
  - i_or_d=1 and mem_read held through MEM_RD.
  - reg_write with mem_to_reg=1 once.
- BEQ (1100):
  - zero=1 gives pc_en=1, pc_src=1 in BRANCH.
  - zero=0 gives no pc_en in BRANCH.
  - Both cases return to FETCH after 3 cycles.
- J (0011):
  - imm_sel=10 and rd1_sel=00.
  - JUMP drives alu_src_b=11 with pc_en=1; 3 cycles total.
- I-type 0001 vs 0100:
  - WB_I reg_dst=1 vs 0.
  - rd1_sel=01 vs 10.
  - alu_src_b=10 in EXEC_I.
- HALT and reset:
  - Opcode 1111 gives halted=1 held for 20 cycles with no enables.
  - Reset asserted during a MEM_WR wait gives mem_write=0 that cycle, then FETCH.
